// File: rtl/mem_arbiter.sv
// Serialises NUM_PORTS memory masters onto one synchronous memory with fixed access latency.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority with port 0 highest.
module mem_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                m_req,
  input  logic [NUM_PORTS-1:0]                m_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     m_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     m_wdata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] m_sel,
  output logic [NUM_PORTS-1:0]                m_ack,
  output logic [DATA_WIDTH-1:0]               m_rdata,
  output logic                                mem_ce,
  output logic                                mem_we,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  output logic [DATA_WIDTH/8-1:0]             mem_sel,
  input  logic [DATA_WIDTH-1:0]               mem_rdata,
  output logic                                busy
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MEM_LATENCY) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] win;
  logic [CW-1:0] cnt;

  logic                  port_we    [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] port_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] port_wdata [NUM_PORTS];
  logic [SW-1:0]         port_sel   [NUM_PORTS];

  genvar g;
  for (g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign port_we[g]    = m_we[g];
    assign port_addr[g]  = m_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_wdata[g] = m_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign port_sel[g]   = m_sel[g*SW +: SW];
  end

  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;

`ifdef MEM_ARB_RR_EN
  // rr_ptr holds the port the next search starts from (last winner + 1).
  logic [IW-1:0] rr_ptr;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!gnt_valid && m_req[(int'(rr_ptr) + k) % NUM_PORTS]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'((int'(rr_ptr) + k) % NUM_PORTS);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (state == S_IDLE && gnt_valid)
      rr_ptr <= (gnt_idx == IW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
  end
`else
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (m_req[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(k);
      end
    end
  end
`endif

  // The mem_* registers double as the command registers, so they read zero outside ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      win       <= '0;
      cnt       <= '0;
      m_ack     <= '0;
      m_rdata   <= '0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sel   <= '0;
    end else begin
      m_ack <= '0;
      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            state     <= S_ACCESS;
            win       <= gnt_idx;
            cnt       <= '0;
            mem_ce    <= 1'b1;
            mem_we    <= port_we[gnt_idx];
            mem_addr  <= port_addr[gnt_idx];
            mem_wdata <= port_wdata[gnt_idx];
            mem_sel   <= port_sel[gnt_idx];
          end
        end
        S_ACCESS: begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state      <= S_ACK;
            m_ack[win] <= 1'b1;
            if (!mem_we)
              m_rdata <= mem_rdata;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_sel   <= '0;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: a transaction-level model predicts every output each cycle.
// Build with or without +define+MEM_ARB_RR_EN; the model follows the same macro.
module tb_mem_arbiter;
  localparam int N = 2, AW = 17, DW = 32, SW = DW / 8, LAT = 2;

  logic clk, rst;
  logic [N-1:0]    m_req, m_we, m_ack;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_sel;
  logic [DW-1:0]   m_rdata, mem_wdata, mem_rdata;
  logic            mem_ce, mem_we, busy;
  logic [AW-1:0]   mem_addr;
  logic [SW-1:0]   mem_sel;

  mem_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_sel(m_sel), .m_ack(m_ack), .m_rdata(m_rdata), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    logic [DW-1:0] h;
    h = {15'd0, a} * 32'h9E3779B9;
    return (a == 17'h10) ? 32'hDEADBEEF : (h ^ 32'hC0FFEE00);
  endfunction

  // Memory only presents valid data in the LAT-th consecutive command cycle.
  int ce_run;
  always @(posedge clk or posedge rst) begin
    if (rst) ce_run <= 0;
    else     ce_run <= mem_ce ? ce_run + 1 : 0;
  end
  always_comb begin
    mem_rdata = 32'hBAD00000 | DW'(ce_run);
    if (mem_ce && ce_run == LAT - 1) mem_rdata = memf(mem_addr);
  end

  // Reference model: transaction in flight occupies 'left' more cycles (LAT access + 1 ack).
  int            left = 0, win = 0, ptr = 0;
  logic          cwe;
  logic [AW-1:0] caddr;
  logic [DW-1:0] cwdata, rdata_m = '0;
  logic [SW-1:0] csel;

  bit            pend   [N];
  logic          pwe    [N];
  logic [AW-1:0] paddr  [N];
  logic [DW-1:0] pwdata [N];
  logic [SW-1:0] psel   [N];

  int cyc = 0, ack_cyc [N];
  bit rel_rst = 0, cont_seen = 0;
  int last_cyc = 0, last_port = 0, lo_acks = 0, hi_acks = 0;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      m_req[i]           = pend[i];
      m_we[i]            = pwe[i];
      m_addr[i*AW +: AW] = paddr[i];
      m_wdata[i*DW +: DW] = pwdata[i];
      m_sel[i*SW +: SW]  = psel[i];
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    pend[i] = 1'b1; pwe[i] = we; paddr[i] = a; pwdata[i] = d; psel[i] = s;
  endtask

  // mode 0: random new requests, 1: every master always requests, 2: only held requests
  task automatic step(input int mode);
    logic [N-1:0] ea;
    int start, found;
    @(negedge clk);
    cyc++;
    ea = '0;
    if (left == 1) ea[win] = 1'b1;
    chk("m_ack",     64'(m_ack),     64'(ea));
    chk("busy",      64'(busy),      64'(left > 0));
    chk("mem_ce",    64'(mem_ce),    64'(left > 1));
    chk("mem_we",    64'(mem_we),    64'((left > 1) ? cwe : 1'b0));
    chk("mem_addr",  64'(mem_addr),  64'((left > 1) ? caddr : '0));
    chk("mem_wdata", 64'(mem_wdata), 64'((left > 1) ? cwdata : '0));
    chk("mem_sel",   64'(mem_sel),   64'((left > 1) ? csel : '0));
    chk("m_rdata",   64'(m_rdata),   64'(rdata_m));

    for (int i = 0; i < N; i++) begin
      if (ea[i]) begin
        pend[i]    = 1'b0;
        ack_cyc[i] = cyc;
        if (mode == 1) begin
          if (cont_seen) begin
            chk("cont_gap", 64'(cyc - last_cyc), 64'(LAT + 2));
`ifdef MEM_ARB_RR_EN
            chk("rr_alternate", 64'(i), 64'((last_port + 1) % N));
`else
            if (i == 0) lo_acks++;
            else        hi_acks++;
`endif
          end
          cont_seen = 1'b1; last_cyc = cyc; last_port = i;
        end
      end
      if (!pend[i]) begin
        pwe[i] = 1'($urandom); paddr[i] = AW'($urandom);
        pwdata[i] = $urandom;  psel[i] = SW'($urandom);
        if (mode == 1 || (mode == 0 && $urandom_range(0, 99) < 35)) pend[i] = 1'b1;
      end
    end
    drive();
    if (rel_rst) begin rst = 1'b0; rel_rst = 1'b0; end

    if (!rst) begin
      if (left > 0) begin
        if (left == 2 && !cwe) rdata_m = memf(caddr);
        left--;
      end else begin
`ifdef MEM_ARB_RR_EN
        start = ptr;
`else
        start = 0;
`endif
        found = -1;
        for (int k = 0; k < N; k++)
          if (found < 0 && pend[(start + k) % N]) found = (start + k) % N;
        if (found >= 0) begin
          win = found; left = LAT + 1; ptr = (found + 1) % N;
          cwe = pwe[found]; caddr = paddr[found]; cwdata = pwdata[found]; csel = psel[found];
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0; psel[i] = '0; ack_cyc[i] = 0;
    end
    drive();
    #1 rst = 1'b1;
    step(2); step(2);
    rel_rst = 1'b1; step(2);

    // port 0 read of the DEADBEEF location
    set_req(0, 1'b0, 17'h10, '0, 4'hF);
    repeat (LAT + 3) step(2);
    chk("read_rdata", 64'(m_rdata), 64'(32'hDEADBEEF));

    // port 1 partial write leaves m_rdata alone
    set_req(1, 1'b1, 17'h100, 32'h12345678, 4'b0011);
    repeat (LAT + 3) step(2);
    chk("write_keeps_rdata", 64'(m_rdata), 64'(32'hDEADBEEF));
    chk("write_acked_port1", 64'(ack_cyc[1] > ack_cyc[0]), 64'(1));

    // port 1 arrives while port 0 is in ACCESS: served right after, no gap
    set_req(0, 1'b0, 17'h40, '0, 4'hF);
    step(2); step(2);
    set_req(1, 1'b0, 17'h80, '0, 4'hF);
    repeat (2 * LAT + 4) step(2);
    chk("late_req_no_gap", 64'(ack_cyc[1] - ack_cyc[0]), 64'(LAT + 2));

    // asynchronous reset in the first ACCESS cycle, then a clean restart
    set_req(0, 1'b0, 17'h2A4, '0, 4'hF);
    step(2); step(2);
    #2 rst = 1'b1;
    #1;
    chk("rst_mem_ce",    64'(mem_ce),    64'(0));
    chk("rst_mem_we",    64'(mem_we),    64'(0));
    chk("rst_mem_addr",  64'(mem_addr),  64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_mem_sel",   64'(mem_sel),   64'(0));
    chk("rst_m_ack",     64'(m_ack),     64'(0));
    chk("rst_m_rdata",   64'(m_rdata),   64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    left = 0; rdata_m = '0; ptr = 0;
    rel_rst = 1'b1; step(2);
    repeat (LAT + 3) step(2);
    chk("restart_rdata", 64'(m_rdata), 64'(memf(17'h2A4)));

    repeat (1500) step(0);

    // both masters request continuously
    cont_seen = 1'b0; lo_acks = 0; hi_acks = 0;
    repeat (60) step(1);
`ifndef MEM_ARB_RR_EN
    chk("fixed_p1_starved", 64'(hi_acks), 64'(0));
    chk("fixed_p0_served",  64'(lo_acks > 5), 64'(1));
`endif
    repeat (10) step(2);
    repeat (1000) step(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
